// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial RAM port arbiter for ROB stores, LSB loads and
// instruction fetches. Little-endian, one byte per cycle, with the RAM read
// byte for mem_a presented on mem_din during the cycle after mem_a is registered.
//
// Optional build macro: MEM_IO_FULL_STALL_EN
//   defined   - a store into the IO region waits while io_buffer_full is high
//   undefined - io_buffer_full is ignored
//
// state | meaning
// IDLE  | no transfer; arbitrates store > load > fetch
// STORE | writing bytes 1..N-1 of an accepted store, then finish_store
// LOAD  | reading N bytes for the LSB, then load_done
// FETCH | reading 4 bytes for ifetch, then if_done

module mem_ctrl #(
    parameter int IO_SEL_HI = 17,
    parameter int IO_SEL_LO = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rollback,
    input  logic        rob_store_sgn,
    input  logic [5:0]  rob_store_op,
    input  logic [31:0] rob_store_addr,
    input  logic [31:0] rob_store_data,
    output logic        begin_real_store,
    output logic        finish_store,
    input  logic        lsb_load_req,
    input  logic [5:0]  lsb_load_op,
    input  logic [31:0] lsb_load_addr,
    output logic        load_done,
    output logic [31:0] load_data,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_inst,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    localparam logic [5:0] OP_LB  = 6'd1;
    localparam logic [5:0] OP_LH  = 6'd2;
    localparam logic [5:0] OP_LW  = 6'd3;
    localparam logic [5:0] OP_LBU = 6'd4;
    localparam logic [5:0] OP_LHU = 6'd5;
    localparam logic [5:0] OP_SB  = 6'd6;
    localparam logic [5:0] OP_SH  = 6'd7;
    localparam logic [5:0] OP_SW  = 6'd8;

    typedef enum logic [1:0] {IDLE, STORE, LOAD, FETCH} state_t;

    state_t      state;
    logic [2:0]  cnt;
    logic [2:0]  len;
    logic [31:0] base;
    logic [31:0] sdata;
    logic [31:0] asm_buf;
    logic [31:0] asm_next;
    logic [5:0]  lop;
    logic        io_hit;
    logic        store_go;

    function automatic logic [2:0] len_of(input logic [5:0] op);
        case (op)
            OP_SB, OP_LB, OP_LBU: len_of = 3'd1;
            OP_SH, OP_LH, OP_LHU: len_of = 3'd2;
            default:              len_of = 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [5:0] op, input logic [31:0] w);
        case (op)
            OP_LB:   extend = {{24{w[7]}}, w[7:0]};
            OP_LH:   extend = {{16{w[15]}}, w[15:0]};
            OP_LBU:  extend = {24'd0, w[7:0]};
            OP_LHU:  extend = {16'd0, w[15:0]};
            OP_LW:   extend = w;
            default: extend = w;
        endcase
    endfunction

    assign io_hit = (rob_store_addr[IO_SEL_HI:IO_SEL_LO] == 2'b11);

`ifdef MEM_IO_FULL_STALL_EN
    assign store_go = rob_store_sgn && !(io_hit && io_buffer_full);
`else
    logic unused_io;
    assign unused_io = io_hit ^ io_buffer_full;
    assign store_go  = rob_store_sgn;
`endif

    // Merge the byte currently on mem_din into the assembly buffer
    always_comb begin
        asm_next = asm_buf;
        asm_next[8*cnt[1:0] +: 8] = mem_din;
    end

    // Arbitration and byte-serial sequencing; all outputs registered here
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            cnt              <= 3'd0;
            len              <= 3'd0;
            base             <= 32'd0;
            sdata            <= 32'd0;
            asm_buf          <= 32'd0;
            lop              <= 6'd0;
            begin_real_store <= 1'b0;
            finish_store     <= 1'b0;
            load_done        <= 1'b0;
            load_data        <= 32'd0;
            if_done          <= 1'b0;
            if_inst          <= 32'd0;
            mem_dout         <= 8'd0;
            mem_a            <= 32'd0;
            mem_wr           <= 1'b0;
        end else if (!rdy) begin
            // Frozen: only the pulses and the write strobe drop
            begin_real_store <= 1'b0;
            finish_store     <= 1'b0;
            load_done        <= 1'b0;
            if_done          <= 1'b0;
            mem_wr           <= 1'b0;
        end else begin
            begin_real_store <= 1'b0;
            finish_store     <= 1'b0;
            load_done        <= 1'b0;
            if_done          <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rollback) begin
                        if (store_go) begin
                            begin_real_store <= 1'b1;
                            mem_wr           <= 1'b1;
                            mem_a            <= rob_store_addr;
                            mem_dout         <= rob_store_data[7:0];
                            base             <= rob_store_addr;
                            sdata            <= rob_store_data;
                            len              <= len_of(rob_store_op);
                            cnt              <= 3'd1;
                            state            <= STORE;
                        end else if (lsb_load_req) begin
                            mem_wr  <= 1'b0;
                            mem_a   <= lsb_load_addr;
                            base    <= lsb_load_addr;
                            lop     <= lsb_load_op;
                            len     <= len_of(lsb_load_op);
                            cnt     <= 3'd0;
                            asm_buf <= 32'd0;
                            state   <= LOAD;
                        end else if (if_req) begin
                            mem_wr  <= 1'b0;
                            mem_a   <= if_addr;
                            base    <= if_addr;
                            len     <= 3'd4;
                            cnt     <= 3'd0;
                            asm_buf <= 32'd0;
                            state   <= FETCH;
                        end
                    end
                end
                STORE: begin
                    // A committed store always runs to completion, rollback or not
                    if (cnt == len) begin
                        mem_wr       <= 1'b0;
                        mem_a        <= 32'd0;
                        finish_store <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        mem_wr   <= 1'b1;
                        mem_a    <= base + {29'd0, cnt};
                        mem_dout <= sdata[8*cnt[1:0] +: 8];
                        cnt      <= cnt + 3'd1;
                    end
                end
                LOAD, FETCH: begin
                    if (rollback) begin
                        mem_wr <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        asm_buf <= asm_next;
                        if (cnt == len - 3'd1) begin
                            if (state == LOAD) begin
                                load_done <= 1'b1;
                                load_data <= extend(lop, asm_next);
                            end else begin
                                if_done <= 1'b1;
                                if_inst <= asm_next;
                            end
                            state <= IDLE;
                        end else begin
                            mem_a <= base + {29'd0, cnt} + 32'd1;
                            cnt   <= cnt + 3'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Memory-side responder for the ROB store-commit handshake (`rob_store_sgn` / `begin_real_store` / `finish_store`).
- Also serves LSB loads and instruction-fetch reads.
- Arbitrates all three onto the single byte-serial RAM port. Little-endian, one byte per cycle, 1-cycle read latency.
- Sits between rob/lsb/ifetch and the top-level RAM/IO bus.

Parameters:
- IO_SEL_HI, 17: upper bit of the IO-region select field.
- IO_SEL_LO, 16: lower bit of the IO-region select field. The address is IO when addr[IO_SEL_HI:IO_SEL_LO]==2'b11.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- rdy  in  1  global enable; low freezes all state.
- rollback  in  1  flush; aborts the in-flight load or fetch.
- rob_store_sgn  in  1  store request level; held by the ROB until begin_real_store.
- rob_store_op  in  6  `SB/`SH/`SW (defines.v).
- rob_store_addr  in  32  store byte address.
- rob_store_data  in  32  store data; low bytes used for SB/SH.
- begin_real_store  out  1  1-cycle pulse: store accepted.
- finish_store  out  1  1-cycle pulse: last byte written.
- lsb_load_req  in  1  load request level; held until load_done.
- lsb_load_op  in  6  `LB/`LH/`LW/`LBU/`LHU.
- lsb_load_addr  in  32  load address.
- load_done  out  1  1-cycle pulse; load_data valid in the same cycle.
- load_data  out  32  sign- or zero-extended load result.
- if_req  in  1  fetch request level; held until if_done.
- if_addr  in  32  fetch address.
- if_done  out  1  1-cycle pulse; if_inst valid.
- if_inst  out  32  fetched instruction.
- mem_din  in  8  RAM read byte.
- mem_dout  out  8  RAM write byte.
- mem_a  out  32  RAM byte address.
- mem_wr  out  1  1 = write, 0 = read.
- io_buffer_full  in  1  UART TX buffer full.

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE; every output 0; byte counter 0; assembly buffer 0.
- rdy=0: no state change. Outputs hold, except pulses: done/begin/finish are forced 0 and mem_wr is forced 0.
- States: IDLE, STORE, LOAD, FETCH.
- N = byte count: 1 for B, 2 for H, 4 for W and fetch.

IDLE:
- Priority is store > load > fetch. A request is sampled at edge E0.
- Store accepted: at E0 set begin_real_store=1, mem_wr=1, mem_a=addr, mem_dout=data[7:0]; go to STORE.
- Load or fetch accepted: at E0 set mem_wr=0, mem_a=addr; go to LOAD or FETCH.
- A request not accepted stays pending.

STORE:
- At edge Ek (k=1..N-1): mem_a=addr+k, mem_dout=data[8k+7:8k], mem_wr=1.
- At edge EN: mem_wr=0, mem_a=0, finish_store=1, return to IDLE.
- SW therefore gives finish_store 4 cycles after begin_real_store; SB gives 1 cycle.

LOAD / FETCH:
- The byte for address k is on mem_din during the cycle after mem_a=addr+k was registered. It is captured at edge E(k+1).
- At edges E1..E(N-1), mem_a advances to addr+k.
- At edge EN, the last byte is captured and load_done=1 (or if_done=1) with the assembled word. Return to IDLE.
- Extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.

Inter-operation rules:
- After any completion there is at least one IDLE cycle, so the next accept is at E(N+1) or later.
- Pulses last exactly one cycle. load_data and if_inst hold until the next completion.

Rollback:
- In LOAD/FETCH: abort and go to IDLE next edge; no done pulse; mem_wr=0.
- In STORE: ignored; the committed store completes and finish_store is still pulsed.
- In IDLE: nothing is accepted that cycle.
- Rollback together with rst: rst wins.

Address arithmetic is 32-bit wrapping; alignment is not checked.

Optional Feature:
- Macro: MEM_IO_FULL_STALL_EN.
- Defined: a store whose addr hits the IO region is not accepted while io_buffer_full=1. It stays pending, with no begin_real_store and with loads/fetches still blocked behind it, until io_buffer_full=0.
- Not defined: io_buffer_full is ignored and IO stores proceed immediately.

Test Plan:
- Reset, then SW addr=0x100 data=0x11223344: begin_real_store at E0. Writes 0x44@0x100, 0x33@0x101, 0x22@0x102, 0x11@0x103 with mem_wr=1. finish_store 4 cycles after begin.
- RAM bytes 0x80,0xFF at 0x200. LH -> load_done 2 cycles after accept, load_data=0xFFFFFF80. LHU at the same address -> 0x0000FF80.
- Store, load and fetch requested in the same cycle -> store served first, then load, then fetch. Each is separated by one IDLE cycle; every done/finish is a single-cycle pulse.
- Rollback asserted during the 2nd byte of a fetch -> FETCH aborted, no if_done, IDLE next cycle. Rollback during SW byte 1 -> all 4 bytes written and finish_store pulsed.
- rdy=0 for 3 cycles mid-LW -> mem_a is frozen and no byte is skipped. load_data is correct after resume.
- With MEM_IO_FULL_STALL_EN and io_buffer_full=1, SB to 0x30000 -> no begin_real_store. io_buffer_full=0 -> accepted next edge, byte written at 0x30000.
